// File: rtl/uart_fifo_bridge.sv
// Byte-stream buffer between a UART PHY byte interface and valid/ready streams.
// TX FIFO drained by a start/done handshake FSM; RX FIFO fed by PHY strobes with sticky overflow.
module uart_fifo_bridge #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic [7:0]       s_tx_data,
    input  logic             s_tx_valid,
    output logic             s_tx_ready,
    output logic [7:0]       byte_tx,
    output logic             start_tx,
    input  logic             done_tx,
    input  logic [7:0]       byte_rx,
    input  logic             new_byte_rx,
    output logic [7:0]       m_rx_data,
    output logic             m_rx_valid,
    input  logic             m_rx_ready,
    output logic [LVL_W-1:0] tx_level,
    output logic [LVL_W-1:0] rx_level,
    output logic             rx_overflow,
    input  logic             clr_overflow,
    output logic             tx_busy
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_ARM  = 2'd1,
        T_BUSY = 2'd2
    } tx_state_t;

    logic [7:0]       r_tx_mem [DEPTH];
    logic [AW-1:0]    r_tx_wr;
    logic [AW-1:0]    r_tx_rd;
    logic [LVL_W-1:0] r_tx_lvl;
    logic [7:0]       r_rx_mem [DEPTH];
    logic [AW-1:0]    r_rx_wr;
    logic [AW-1:0]    r_rx_rd;
    logic [LVL_W-1:0] r_rx_lvl;
    logic             r_rx_ovf;
    tx_state_t        r_state;
    logic             r_start;
    logic [7:0]       r_byte;

    tx_state_t        w_state_nxt;
    logic             w_start_nxt;
    logic [7:0]       w_byte_nxt;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic             w_tx_push;
    logic             w_tx_pop;
    logic             w_rx_full;
    logic             w_rx_valid;
    logic             w_rx_push;
    logic             w_rx_pop;
    logic             w_rx_drop;

    assign w_tx_full  = (r_tx_lvl == LVL_W'(DEPTH));
    assign w_tx_empty = (r_tx_lvl == '0);
    assign w_tx_push  = s_tx_valid && !w_tx_full;
    assign w_rx_full  = (r_rx_lvl == LVL_W'(DEPTH));
    assign w_rx_valid = (r_rx_lvl != '0);
    assign w_rx_pop   = w_rx_valid && m_rx_ready;
    // A full RX FIFO still takes a byte when the head leaves in the same cycle.
    assign w_rx_push  = new_byte_rx && (!w_rx_full || w_rx_pop);
    assign w_rx_drop  = new_byte_rx && w_rx_full && !w_rx_pop;

    assign s_tx_ready  = !w_tx_full;
    assign byte_tx     = r_byte;
    assign start_tx    = r_start;
    assign m_rx_data   = r_rx_mem[r_rx_rd];
    assign m_rx_valid  = w_rx_valid;
    assign tx_level    = r_tx_lvl;
    assign rx_level    = r_rx_lvl;
    assign rx_overflow = r_rx_ovf;
    assign tx_busy     = !w_tx_empty || (r_state != T_IDLE);

    // FIFO storage needs no reset; pointers and levels define validity.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= s_tx_data;
        if (w_rx_push) r_rx_mem[r_rx_wr] <= byte_rx;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_lvl <= '0;
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_lvl <= '0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + AW'(1);
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + AW'(1);
            if (w_tx_push && !w_tx_pop)      r_tx_lvl <= r_tx_lvl + LVL_W'(1);
            else if (!w_tx_push && w_tx_pop) r_tx_lvl <= r_tx_lvl - LVL_W'(1);

            if (w_rx_push) r_rx_wr <= r_rx_wr + AW'(1);
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + AW'(1);
            if (w_rx_push && !w_rx_pop)      r_rx_lvl <= r_rx_lvl + LVL_W'(1);
            else if (!w_rx_push && w_rx_pop) r_rx_lvl <= r_rx_lvl - LVL_W'(1);

            if (w_rx_drop)         r_rx_ovf <= 1'b1;
            else if (clr_overflow) r_rx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state <= T_IDLE;
            r_start <= 1'b0;
            r_byte  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_byte  <= w_byte_nxt;
        end
    end

    // T_ARM exits only on done_tx low, absorbing the PHY's late drop of done_tx.
    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = 1'b0;
        w_byte_nxt  = r_byte;
        w_tx_pop    = 1'b0;
        case (r_state)
            T_IDLE: begin
                if (!w_tx_empty && done_tx) begin
                    w_byte_nxt  = r_tx_mem[r_tx_rd];
                    w_start_nxt = 1'b1;
                    w_tx_pop    = 1'b1;
                    w_state_nxt = T_ARM;
                end
            end
            T_ARM: begin
                if (!done_tx) w_state_nxt = T_BUSY;
            end
            T_BUSY: begin
                if (done_tx) w_state_nxt = T_IDLE;
            end
            default: w_state_nxt = T_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Randomized scoreboard bench for uart_fifo_bridge with a behavioural PHY and queue-based FIFO model.
module tb_uart_fifo_bridge;
    localparam int DEPTH = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             arstn;
    logic [7:0]       s_tx_data;
    logic             s_tx_valid;
    logic             s_tx_ready;
    logic [7:0]       byte_tx;
    logic             start_tx;
    logic             done_tx;
    logic [7:0]       byte_rx;
    logic             new_byte_rx;
    logic [7:0]       m_rx_data;
    logic             m_rx_valid;
    logic             m_rx_ready;
    logic [LVL_W-1:0] tx_level;
    logic [LVL_W-1:0] rx_level;
    logic             rx_overflow;
    logic             clr_overflow;
    logic             tx_busy;

    uart_fifo_bridge #(.DEPTH(DEPTH)) dut (
        .clk(clk), .arstn(arstn),
        .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready),
        .byte_tx(byte_tx), .start_tx(start_tx), .done_tx(done_tx),
        .byte_rx(byte_rx), .new_byte_rx(new_byte_rx),
        .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid), .m_rx_ready(m_rx_ready),
        .tx_level(tx_level), .rx_level(rx_level),
        .rx_overflow(rx_overflow), .clr_overflow(clr_overflow), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Behavioural PHY: drops done_tx phy_hold cycles after seeing start, stays low for 10 bit-times.
    int   phy_st = 0;
    int   phy_cnt = 0;
    int   phy_hold = 1;
    logic phy_block = 1'b0;

    initial begin
        done_tx = 1'b1;
        forever begin
            @(negedge clk); #1;
            if (!arstn) begin
                phy_st  = 0;
                done_tx = !phy_block;
            end else begin
                case (phy_st)
                    0: begin
                        done_tx = !phy_block;
                        if (start_tx) begin
                            phy_cnt = phy_hold;
                            phy_st  = 1;
                        end
                    end
                    1: begin
                        phy_cnt--;
                        if (phy_cnt <= 0) begin
                            done_tx = 1'b0;
                            phy_cnt = 10;
                            phy_st  = 2;
                        end
                    end
                    default: begin
                        phy_cnt--;
                        if (phy_cnt <= 0) begin
                            done_tx = !phy_block;
                            phy_st  = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Reference model: queues updated at each negedge from the inputs seen by the preceding edge.
    logic [7:0] q_tx[$];
    logic [7:0] q_rx[$];
    logic       ovf_m = 1'b0;
    logic [7:0] last_load = 8'h00;
    logic       prev_start = 1'b0;
    logic       m_tx_acc;
    logic       m_rx_pop;
    logic       m_rx_drop;
    logic [7:0] m_exp;
    int         n_starts = 0;
    int         n_tx_acc = 0;
    int         n_rx_new = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!arstn) begin
                q_tx.delete();
                q_rx.delete();
                ovf_m      = 1'b0;
                last_load  = 8'h00;
                prev_start = 1'b0;
            end else begin
                m_tx_acc = s_tx_valid && (q_tx.size() < DEPTH);
                if (start_tx) begin
                    n_starts++;
                    check("start_double", 32'(prev_start), 32'd0);
                    check("start_phy_idle", 32'(phy_st), 32'd0);
                    if (q_tx.size() == 0) begin
                        fail_now("tx_start_with_empty_model_queue");
                    end else begin
                        m_exp = q_tx.pop_front();
                        check("tx_byte", 32'(byte_tx), 32'(m_exp));
                        last_load = m_exp;
                    end
                end else begin
                    check("tx_byte_hold", 32'(byte_tx), 32'(last_load));
                end
                prev_start = start_tx;
                if (m_tx_acc) begin
                    q_tx.push_back(s_tx_data);
                    n_tx_acc++;
                end
                check("tx_level", 32'(tx_level), 32'(q_tx.size()));
                check("tx_ready", 32'(s_tx_ready), 32'(q_tx.size() < DEPTH));

                m_rx_pop  = (q_rx.size() != 0) && m_rx_ready;
                m_rx_drop = new_byte_rx && (q_rx.size() == DEPTH) && !m_rx_pop;
                if (m_rx_pop) void'(q_rx.pop_front());
                if (new_byte_rx && !m_rx_drop) begin
                    q_rx.push_back(byte_rx);
                    n_rx_new++;
                end
                if (m_rx_drop)         ovf_m = 1'b1;
                else if (clr_overflow) ovf_m = 1'b0;
                check("rx_valid", 32'(m_rx_valid), 32'(q_rx.size() != 0));
                if (q_rx.size() != 0) check("rx_head", 32'(m_rx_data), 32'(q_rx[0]));
                check("rx_level", 32'(rx_level), 32'(q_rx.size()));
                check("rx_overflow", 32'(rx_overflow), 32'(ovf_m));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        s_tx_data  = b;
        s_tx_valid = 1'b1;
        cyc(1);
        s_tx_valid = 1'b0;
    endtask

    task automatic rx_strobe(input logic [7:0] b);
        byte_rx     = b;
        new_byte_rx = 1'b1;
        cyc(1);
        new_byte_rx = 1'b0;
    endtask

    task automatic wait_tx_idle(input int budget);
        int k = 0;
        while (!(q_tx.size() == 0 && phy_st == 0 && !start_tx) && k < budget) begin
            cyc(1);
            k++;
        end
        if (k >= budget) fail_now("tx_drain_timeout");
        cyc(2);
    endtask

    task automatic rx_drain(input int budget);
        int k = 0;
        m_rx_ready = 1'b1;
        while (q_rx.size() != 0 && k < budget) begin
            cyc(1);
            k++;
        end
        m_rx_ready = 1'b0;
        if (k >= budget) fail_now("rx_drain_timeout");
        cyc(1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_start"},    32'(start_tx),    32'd0);
        check({tag, "_byte_tx"},  32'(byte_tx),     32'd0);
        check({tag, "_rx_valid"}, 32'(m_rx_valid),  32'd0);
        check({tag, "_tx_ready"}, 32'(s_tx_ready),  32'd1);
        check({tag, "_ovf"},      32'(rx_overflow), 32'd0);
        check({tag, "_busy"},     32'(tx_busy),     32'd0);
        check({tag, "_tx_lvl"},   32'(tx_level),    32'd0);
        check({tag, "_rx_lvl"},   32'(rx_level),    32'd0);
    endtask

    int s0;
    int base_tx;
    int base_rx;
    int k;

    initial begin
        arstn = 1'b0; s_tx_valid = 1'b0; s_tx_data = 8'h00; byte_rx = 8'h00;
        new_byte_rx = 1'b0; m_rx_ready = 1'b0; clr_overflow = 1'b0;
        cyc(3);
        check_reset_values("rst");
        arstn = 1'b1;
        cyc(2);

        // Single byte frame
        s0 = n_starts;
        push_tx(8'hA5);
        wait_tx_idle(500);
        check("t1_starts", 32'(n_starts - s0), 32'd1);
        check("t1_byte", 32'(byte_tx), 32'hA5);
        check("t1_busy", 32'(tx_busy), 32'd0);

        // Fill TX FIFO while PHY busy, then drain in order
        phy_block = 1'b1;
        cyc(2);
        for (int i = 1; i <= DEPTH; i++) push_tx(8'(i));
        check("t2_level_full", 32'(tx_level), 32'(DEPTH));
        check("t2_ready_low", 32'(s_tx_ready), 32'd0);
        push_tx(8'h99);
        check("t2_extra_rejected", 32'(tx_level), 32'(DEPTH));
        s0 = n_starts;
        phy_block = 1'b0;
        wait_tx_idle(2000);
        check("t2_starts", 32'(n_starts - s0), 32'(DEPTH));
        check("t2_last_byte", 32'(byte_tx), 32'h10);

        // RX fill and overflow drop
        for (int i = 0; i < DEPTH; i++) rx_strobe(8'(8'h11 + i));
        check("t3_level", 32'(rx_level), 32'(DEPTH));
        check("t3_no_ovf_yet", 32'(rx_overflow), 32'd0);
        rx_strobe(8'h55);
        check("t3_level_after_drop", 32'(rx_level), 32'(DEPTH));
        check("t3_ovf", 32'(rx_overflow), 32'd1);
        check("t3_head", 32'(m_rx_data), 32'h11);
        rx_drain(100);
        check("t3_empty", 32'(rx_level), 32'd0);
        check("t3_ovf_sticky", 32'(rx_overflow), 32'd1);
        clr_overflow = 1'b1; cyc(1); clr_overflow = 1'b0;
        check("t3_ovf_cleared", 32'(rx_overflow), 32'd0);

        // Push into full RX FIFO alongside a pop; set beats clear
        for (int i = 0; i < DEPTH; i++) rx_strobe(8'(8'h60 + i));
        byte_rx = 8'h77; new_byte_rx = 1'b1; m_rx_ready = 1'b1;
        cyc(1);
        new_byte_rx = 1'b0; m_rx_ready = 1'b0;
        check("t4_no_ovf", 32'(rx_overflow), 32'd0);
        check("t4_level", 32'(rx_level), 32'(DEPTH));
        check("t4_head", 32'(m_rx_data), 32'h61);
        byte_rx = 8'h88; new_byte_rx = 1'b1; clr_overflow = 1'b1;
        cyc(1);
        new_byte_rx = 1'b0; clr_overflow = 1'b0;
        check("t4_set_wins", 32'(rx_overflow), 32'd1);
        clr_overflow = 1'b1; cyc(1); clr_overflow = 1'b0;
        check("t4_cleared", 32'(rx_overflow), 32'd0);
        rx_drain(100);
        check("t4_empty", 32'(rx_level), 32'd0);

        // Late done_tx drop: no early second start
        phy_hold = 4;
        s0 = n_starts;
        push_tx(8'h3C);
        push_tx(8'h3D);
        wait_tx_idle(500);
        check("t5_starts", 32'(n_starts - s0), 32'd2);
        check("t5_byte", 32'(byte_tx), 32'h3D);
        phy_hold = 1;

        // Reset mid-frame with bytes queued in both directions
        for (int i = 0; i < 3; i++) rx_strobe(8'(8'hC0 + i));
        for (int i = 0; i < 6; i++) push_tx(8'(8'hD0 + i));
        cyc(4);
        check("t6_queued", 32'(tx_level), 32'd5);
        phy_block = 1'b1;
        arstn = 1'b0;
        cyc(1);
        check_reset_values("t6_rst");
        cyc(1);
        arstn = 1'b1;
        cyc(2);
        s0 = n_starts;
        push_tx(8'h42);
        cyc(6);
        check("t6_no_start", 32'(n_starts - s0), 32'd0);
        check("t6_level", 32'(tx_level), 32'd1);
        check("t6_busy", 32'(tx_busy), 32'd1);
        phy_block = 1'b0;
        wait_tx_idle(500);
        check("t6_start", 32'(n_starts - s0), 32'd1);
        check("t6_byte", 32'(byte_tx), 32'h42);

        // Random streaming across pointer wrap in both directions
        base_tx = n_tx_acc;
        base_rx = n_rx_new;
        k = 0;
        while ((n_tx_acc - base_tx < 40 || n_rx_new - base_rx < 40) && k < 3000) begin
            s_tx_valid  = (n_tx_acc - base_tx < 40) && ($urandom_range(0, 1) == 1);
            s_tx_data   = 8'($urandom);
            new_byte_rx = (n_rx_new - base_rx < 40) && ($urandom_range(0, 2) != 0);
            byte_rx     = 8'($urandom);
            m_rx_ready  = ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            cyc(1);
            k++;
        end
        s_tx_valid = 1'b0; new_byte_rx = 1'b0; m_rx_ready = 1'b0; clr_overflow = 1'b0;
        if (k >= 3000) fail_now("stream_timeout");
        wait_tx_idle(2000);
        rx_drain(200);
        check("wrap_tx_empty", 32'(tx_level), 32'd0);
        check("wrap_rx_empty", 32'(rx_level), 32'd0);
        check("wrap_busy", 32'(tx_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
